// File: rtl/linebuf_seq.sv
// rtl/linebuf_seq.sv - line-buffer chain sequencer: line position, staggered row enables/addresses, fill/flush FSM
// Optional LINEBUF_SEQ_SOF_ERR_EN adds sticky sof_err output for mid-line start-of-frame.
module linebuf_seq #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int NROWS    = 11,
  parameter int AW       = 10
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  en,
  output logic [12:0]           col,
  output logic [12:0]           x_count,
  output logic [NROWS-1:0]      shift_en,
  output logic [NROWS*AW-1:0]   addr_bus,
  output logic                  zero_in,
  output logic [3:0]            rows_filled,
  output logic                  win_valid,
  output logic                  line_end,
  output logic                  busy
`ifdef LINEBUF_SEQ_SOF_ERR_EN
  ,
  output logic                  sof_err
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0] state;
  logic [9:0] line_cnt;
  logic [9:0] line_cnt_nxt;
  logic [3:0] rows_nxt;

  assign busy         = (state != IDLE);
  assign zero_in      = (state == FLUSH);
  assign line_end     = (x_count == 13'(H_TOTAL - 1));
  assign col          = (x_count < 13'(H_ACTIVE)) ? x_count : 13'(H_ACTIVE - 1);
  assign line_cnt_nxt = line_cnt + 10'd1;
  assign rows_nxt     = (rows_filled == 4'(NROWS)) ? rows_filled : rows_filled + 4'd1;

  // Row i runs i columns ahead, so its write window starts i clocks early in the previous blanking.
  for (genvar i = 0; i < NROWS; i++) begin : g_row
    localparam logic [12:0]   LO   = 13'(H_ACTIVE - i);
    localparam logic [12:0]   HI   = 13'(H_TOTAL - 1 - i);
    localparam logic [AW-1:0] AMAX = AW'(H_ACTIVE - 1);
    logic [AW-1:0] sum;
    assign sum                 = x_count[AW-1:0] + AW'(i);
    assign addr_bus[i*AW +: AW] = (sum > AMAX) ? '0 : sum;
    assign shift_en[i]         = en && busy && ((x_count < LO) || (x_count > HI));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_count     <= '0;
      line_cnt    <= '0;
      rows_filled <= '0;
      win_valid   <= 1'b0;
    end else begin
      win_valid <= ((state == RUN) || (state == FLUSH)) && (x_count < 13'(H_ACTIVE));
      if (sof && busy) begin
        // Restart abandons the current frame without draining it.
        state       <= FILL;
        x_count     <= '0;
        line_cnt    <= '0;
        rows_filled <= '0;
      end else if (state == IDLE) begin
        x_count <= '0;
        if (sof) state <= FILL;
      end else begin
        x_count <= line_end ? '0 : x_count + 13'd1;
        if (line_end) begin
          line_cnt <= line_cnt_nxt;
          case (state)
            FILL: begin
              rows_filled <= rows_nxt;
              if (rows_nxt == 4'(NROWS)) state <= RUN;
            end
            RUN: begin
              if (line_cnt_nxt == 10'(V_ACTIVE)) begin
                state    <= FLUSH;
                line_cnt <= '0;
              end
            end
            default: begin
              if (line_cnt_nxt == 10'(NROWS)) begin
                state       <= IDLE;
                line_cnt    <= '0;
                rows_filled <= '0;
              end
            end
          endcase
        end
      end
    end
  end

`ifdef LINEBUF_SEQ_SOF_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  sof_err <= 1'b0;
    else if (sof && busy && (x_count != '0))  sof_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_linebuf_seq.sv
// tb/tb_linebuf_seq.sv - randomized-enable bench for linebuf_seq against a frame-level line/column model
// Optional LINEBUF_SEQ_SOF_ERR_EN also checks sof_err.
module tb_linebuf_seq;

  localparam int HA = 640;
  localparam int HT = 800;
  localparam int VA = 16;
  localparam int NR = 11;
  localparam int AW = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sof = 1'b0;
  logic               en  = 1'b0;
  logic [12:0]        col;
  logic [12:0]        x_count;
  logic [NR-1:0]      shift_en;
  logic [NR*AW-1:0]   addr_bus;
  logic               zero_in;
  logic [3:0]         rows_filled;
  logic               win_valid;
  logic               line_end;
  logic               busy;
`ifdef LINEBUF_SEQ_SOF_ERR_EN
  logic               sof_err;
`endif

  always #5 clk = ~clk;

  linebuf_seq #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .NROWS(NR), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sof(sof), .en(en),
    .col(col), .x_count(x_count), .shift_en(shift_en), .addr_bus(addr_bus),
    .zero_in(zero_in), .rows_filled(rows_filled), .win_valid(win_valid),
    .line_end(line_end), .busy(busy)
`ifdef LINEBUF_SEQ_SOF_ERR_EN
    , .sof_err(sof_err)
`endif
  );

  int compared   = 0;
  int mismatched = 0;
  bit cmp_on     = 1'b0;

  // Frame model: lines completed since sof decides the phase (fill, run, flush, idle).
  bit m_active  = 1'b0;
  int m_x       = 0;
  int m_lines   = 0;
  bit m_wv      = 1'b0;
  bit m_sof_err = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*AW-1:0] exp_addr(input int x);
    logic [NR*AW-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      int s;
      s = (x + i) % (1 << AW);
      r[i*AW +: AW] = (s > HA - 1) ? '0 : AW'(s);
    end
    return r;
  endfunction

  function automatic logic [NR-1:0] exp_shift(input int x, input bit e, input bit act);
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++)
      r[i] = e && act && ((x < HA - i) || (x > HT - 1 - i));
    return r;
  endfunction

  task automatic model_step(input bit s);
    m_wv = m_active && (m_lines >= NR) && (m_x < HA);
    if (s) begin
      if (m_active && m_x != 0) m_sof_err = 1'b1;
      m_active = 1'b1;
      m_x      = 0;
      m_lines  = 0;
    end else if (m_active) begin
      if (m_x == HT - 1) begin
        m_x = 0;
        m_lines++;
        if (m_lines == VA + NR) m_active = 1'b0;
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_x       = 0;
    m_lines   = 0;
    m_wv      = 1'b0;
    m_sof_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("x_count",     128'(x_count),     128'(m_x));
      chk("col",         128'(col),         128'((m_x < HA) ? m_x : HA - 1));
      chk("line_end",    128'(line_end),    128'(m_x == HT - 1));
      chk("busy",        128'(busy),        128'(m_active));
      chk("zero_in",     128'(zero_in),     128'(m_active && m_lines >= VA));
      chk("rows_filled", 128'(rows_filled), 128'(m_active ? ((m_lines < NR) ? m_lines : NR) : 0));
      chk("win_valid",   128'(win_valid),   128'(m_wv));
      chk("shift_en",    128'(shift_en),    128'(exp_shift(m_x, en, m_active)));
      chk("addr_bus",    128'(addr_bus),    128'(exp_addr(m_x)));
`ifdef LINEBUF_SEQ_SOF_ERR_EN
      chk("sof_err",     128'(sof_err),     128'(m_sof_err));
`endif
    end
  end

  function automatic bit ren();
    return $urandom_range(0, 7) != 0;
  endfunction

  task automatic tick(input bit s, input bit e);
    sof = s;
    en  = e;
    @(posedge clk);
    model_step(s);
    #1;
    sof = 1'b0;
  endtask

  task automatic run_until(input int lines, input int x, input bit rand_en);
    int n;
    n = 0;
    while (!(m_lines == lines && m_x == x) && n < 40000) begin
      tick(1'b0, rand_en ? ren() : 1'b1);
      n++;
    end
    chk("reach_target", 128'(n < 40000), 128'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     128'(busy),                 128'd0);
    chk("rst_x_count",  128'(x_count),              128'd0);
    chk("rst_shift_en", 128'(shift_en),             128'd0);
    chk("rst_addr3",    128'(addr_bus[3*AW +: AW]), 128'd3);
    chk("rst_win",      128'(win_valid),            128'd0);
    @(negedge clk);
    rst    = 1'b0;
    cmp_on = 1'b1;
    repeat (5) tick(1'b0, ren());

    // Asynchronous reset in the middle of the first line
    tick(1'b1, 1'b1);
    run_until(0, 300, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x_count",  128'(x_count),              128'd0);
    chk("arst_busy",     128'(busy),                 128'd0);
    chk("arst_shift_en", 128'(shift_en),             128'd0);
    chk("arst_addr3",    128'(addr_bus[3*AW +: AW]), 128'd3);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick(1'b0, ren());

    // Full frame
    tick(1'b1, 1'b1);
    run_until(0, 632, 1'b0);
    @(negedge clk); #1;
    chk("addr7_at632",  128'(addr_bus[7*AW +: AW]),  128'd639);
    chk("addr8_at632",  128'(addr_bus[8*AW +: AW]),  128'd0);
    chk("addr10_at632", 128'(addr_bus[10*AW +: AW]), 128'd0);
    chk("addr0_at632",  128'(addr_bus[0 +: AW]),     128'd632);
    run_until(0, 635, 1'b0);
    @(negedge clk); #1;
    chk("se4_at635",  128'(shift_en[4]),  128'd1);
    chk("se5_at635",  128'(shift_en[5]),  128'd0);
    chk("se10_at635", 128'(shift_en[10]), 128'd0);
    run_until(0, 795, 1'b0);
    @(negedge clk); #1;
    chk("se4_at795", 128'(shift_en[4]), 128'd0);
    chk("se5_at795", 128'(shift_en[5]), 128'd1);
    run_until(0, 796, 1'b0);
    @(negedge clk); #1;
    chk("se4_at796", 128'(shift_en[4]), 128'd1);
    chk("se3_at796", 128'(shift_en[3]), 128'd0);
    run_until(0, 799, 1'b0);
    @(negedge clk); #1;
    chk("line_end_at799", 128'(line_end), 128'd1);
    run_until(1, 0, 1'b1);
    chk("rows_after_l1", 128'(rows_filled), 128'd1);
    run_until(NR, 0, 1'b1);
    chk("rows_full",     128'(rows_filled), 128'd11);
    chk("win_at_l11_x0", 128'(win_valid),   128'd0);
    tick(1'b0, 1'b1);
    chk("win_first",     128'(win_valid),   128'd1);
    chk("x_after_first", 128'(x_count),     128'd1);
    repeat (200) tick(1'b0, 1'b0);
    chk("gated_shift_en", 128'(shift_en),  128'd0);
    chk("gated_x_count",  128'(x_count),   128'd201);
    chk("gated_win",      128'(win_valid), 128'd1);
    run_until(VA, 0, 1'b1);
    chk("flush_zero_in", 128'(zero_in),     128'd1);
    chk("flush_rows",    128'(rows_filled), 128'd11);
    run_until(VA + NR, 0, 1'b1);
    chk("end_busy",    128'(busy),        128'd0);
    chk("end_zero_in", 128'(zero_in),     128'd0);
    chk("end_rows",    128'(rows_filled), 128'd0);
    repeat (20) tick(1'b0, ren());

    // Second frame interrupted by sof during flush line 5
    tick(1'b1, 1'b1);
    run_until(VA + 5, 123, 1'b1);
    tick(1'b1, 1'b1);
    chk("resof_rows",    128'(rows_filled), 128'd0);
    chk("resof_x",       128'(x_count),     128'd0);
    chk("resof_busy",    128'(busy),        128'd1);
    chk("resof_zero_in", 128'(zero_in),     128'd0);
`ifdef LINEBUF_SEQ_SOF_ERR_EN
    chk("resof_sof_err", 128'(sof_err),     128'd1);
`endif
    run_until(2, 0, 1'b1);
    repeat (10) tick(1'b0, ren());
    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
